// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch decode.
// Circular buffer of {instr, pc, pred_npc, br_taken} entries with wrap-bit
// pointers, a valid/ready handshake on both sides, and a one-cycle flush
// that drops every buffered entry on a redirect.
module instr_queue #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst_aL,
   input  logic                    flush,
   // Fetch side
   input  logic                    enq_valid,
   output logic                    enq_ready,
   input  logic [INSTR_WIDTH-1:0]  enq_instr,
   input  logic [ADDR_WIDTH-1:0]   enq_pc,
   input  logic [ADDR_WIDTH-1:0]   enq_pred_npc,
   input  logic                    enq_br_taken,
   // Decode side
   output logic                    deq_valid,
   input  logic                    deq_ready,
   output logic [INSTR_WIDTH-1:0]  deq_instr,
   output logic [ADDR_WIDTH-1:0]   deq_pc,
   output logic [ADDR_WIDTH-1:0]   deq_pred_npc,
   output logic                    deq_br_taken,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0]  pc;
      logic [ADDR_WIDTH-1:0]  pred_npc;
      logic                   br_taken;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           enq_entry;
   entry_t           head_entry;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic             empty;
   logic             full;
   logic             enq_fire;
   logic             deq_fire;

   // Occupancy flags come from pointer state only, so enq_ready never
   // depends combinationally on deq_ready.
   always_comb begin
      empty = (head_q == tail_q);
      full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
              (head_q[IDX_W] != tail_q[IDX_W]);
   end

   assign enq_ready = !full;
   assign deq_valid = !empty;
   assign count     = tail_q - head_q;

   // Flush wins over both handshakes; a flushed cycle transfers nothing.
   assign enq_fire = enq_valid && enq_ready && !flush;
   assign deq_fire = deq_valid && deq_ready && !flush;

   // Next-state pointers: clear on flush, otherwise advance on each fire.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and infers a latch.
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (deq_fire) head_d = head_q + PTR_W'(1);
         if (enq_fire) tail_d = tail_q + PTR_W'(1);
      end
   end

   // Pointer registers with asynchronous reset to the empty state.
   always_ff @(posedge clk or negedge rst_aL) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_aL) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign enq_entry = '{instr:    enq_instr,
                        pc:       enq_pc,
                        pred_npc: enq_pred_npc,
                        br_taken: enq_br_taken};

   // Payload write at the tail slot.
   always_ff @(posedge clk) begin
      // NOTE: the payload array has no reset; an entry is only observable
      // once the pointers mark it valid, so clearing it buys nothing.
      if (enq_fire) mem_q[tail_q[IDX_W-1:0]] <= enq_entry;
   end

   // Head entry drives decode directly; no empty-queue bypass path.
   assign head_entry   = mem_q[head_q[IDX_W-1:0]];
   assign deq_instr    = head_entry.instr;
   assign deq_pc       = head_entry.pc;
   assign deq_pred_npc = head_entry.pred_npc;
   assign deq_br_taken = head_entry.br_taken;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a queue-based scoreboard follows every
// accepted enqueue and checks the decode side's order, payload and flags.
module tb_instr_queue;

   logic        clk = 1'b0;
   logic        rst_aL;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_instr;
   logic [31:0] enq_pc;
   logic [31:0] enq_pred_npc;
   logic        enq_br_taken;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_instr;
   logic [31:0] deq_pc;
   logic [31:0] deq_pred_npc;
   logic        deq_br_taken;
   logic [3:0]  count;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        br;
   } ent_t;

   ent_t sb[$];
   int   errors = 0;
   int   checks = 0;

   instr_queue #(.DEPTH(8), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk          (clk),
      .rst_aL       (rst_aL),
      .flush        (flush),
      .enq_valid    (enq_valid),
      .enq_ready    (enq_ready),
      .enq_instr    (enq_instr),
      .enq_pc       (enq_pc),
      .enq_pred_npc (enq_pred_npc),
      .enq_br_taken (enq_br_taken),
      .deq_valid    (deq_valid),
      .deq_ready    (deq_ready),
      .deq_instr    (deq_instr),
      .deq_pc       (deq_pc),
      .deq_pred_npc (deq_pred_npc),
      .deq_br_taken (deq_br_taken),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check flags and
   // head payload against the scoreboard, update it, then take the edge.
   task automatic step(input logic ev, input logic [31:0] instr,
                       input logic [31:0] pc, input logic dr, input logic fl);
      int   n;
      logic ef, df;
      ent_t e;
      @(negedge clk);
      enq_valid    = ev;
      enq_instr    = instr;
      enq_pc       = pc;
      enq_pred_npc = pc + 32'd8;
      enq_br_taken = instr[0];
      deq_ready    = dr;
      flush        = fl;
      #1;
      n = sb.size();
      chk("count", 64'(count), 64'(n));
      chk("deq_valid", 64'(deq_valid), 64'(n != 0));
      chk("enq_ready", 64'(enq_ready), 64'(n != 8));
      if (n != 0) begin
         chk("deq_pc", 64'(deq_pc), 64'(sb[0].pc));
         chk("deq_instr", 64'(deq_instr), 64'(sb[0].instr));
         chk("deq_pred_npc", 64'(deq_pred_npc), 64'(sb[0].npc));
         chk("deq_br_taken", 64'(deq_br_taken), 64'(sb[0].br));
      end
      ef = ev && (n != 8) && !fl;
      df = dr && (n != 0) && !fl;
      if (fl) begin
         sb.delete();
      end else begin
         if (df) void'(sb.pop_front());
         if (ef) begin
            e.instr = instr;
            e.pc    = pc;
            e.npc   = pc + 32'd8;
            e.br    = instr[0];
            sb.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   initial begin
      rst_aL       = 1'b0;
      flush        = 1'b0;
      enq_valid    = 1'b0;
      enq_instr    = '0;
      enq_pc       = '0;
      enq_pred_npc = '0;
      enq_br_taken = 1'b0;
      deq_ready    = 1'b0;
      #2;
      // Reset state.
      chk("rst_deq_valid", 64'(deq_valid), 64'(0));
      chk("rst_enq_ready", 64'(enq_ready), 64'(1));
      chk("rst_count", 64'(count), 64'(0));
      @(negedge clk);
      rst_aL = 1'b1;

      // 1. Fill to full, then try a ninth entry.
      for (int i = 0; i < 8; i++) step(1'b1, 32'h13 + i, 32'h1000 + 4 * i, 1'b0, 1'b0);
      #1;
      chk("full_count", 64'(count), 64'(8));
      chk("full_enq_ready", 64'(enq_ready), 64'(0));
      step(1'b1, 32'hBAD, 32'hDEAD, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // 2. Drain in order; scoreboard checks pc 0x1000..0x101C.
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // 3. Hold count at 3 with simultaneous enq/deq for 20 cycles.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + i, 32'h4000 + 4 * i, 1'b0, 1'b0);
      for (int i = 3; i < 23; i++) step(1'b1, 32'h100 + i, 32'h4000 + 4 * i, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // 4. Empty-to-valid latency.
      step(1'b1, 32'h55, 32'h2000, 1'b0, 1'b0);
      #1;
      chk("lat_deq_valid", 64'(deq_valid), 64'(1));
      chk("lat_deq_pc", 64'(deq_pc), 64'(32'h2000));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // 5. Flush with concurrent enq (pc 0x3000) and deq at count 5.
      for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + i, 32'h5000 + 4 * i, 1'b0, 1'b0);
      step(1'b1, 32'h300, 32'h3000, 1'b1, 1'b1);
      #1;
      chk("flush_count", 64'(count), 64'(0));
      chk("flush_deq_valid", 64'(deq_valid), 64'(0));
      step(1'b1, 32'h401, 32'h6000, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // 6. Asynchronous reset between edges at count 4.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + i, 32'h7000 + 4 * i, 1'b0, 1'b0);
      @(negedge clk);
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      #2;
      chk("pre_arst_count", 64'(count), 64'(4));
      rst_aL = 1'b0;
      #1;
      chk("arst_deq_valid", 64'(deq_valid), 64'(0));
      chk("arst_enq_ready", 64'(enq_ready), 64'(1));
      chk("arst_count", 64'(count), 64'(0));
      sb.delete();
      @(negedge clk);
      rst_aL = 1'b1;
      step(1'b1, 32'h601, 32'h8000, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Decoupling FIFO between fetch and the dispatch decode stage.
- Buffers fetched instruction words together with their PC and branch-prediction metadata.
- Presents the oldest entry to decode through a valid/ready handshake.
- Flushes in one cycle on a redirect (branch mispredict or jalr resolution) so no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and ≥ 2.
- INSTR_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_aL  in  1  reset, asynchronous, active-low.
- flush  in  1  redirect; synchronous clear of all entries.
- enq_valid  in  1  fetch presents an entry.
- enq_ready  out  1  queue can accept an entry.
- enq_instr  in  INSTR_WIDTH  instruction word.
- enq_pc  in  ADDR_WIDTH  PC of the instruction.
- enq_pred_npc  in  ADDR_WIDTH  predicted next PC.
- enq_br_taken  in  1  predicted direction; 0 for non-branches.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  decode consumes the head entry.
- deq_instr  out  INSTR_WIDTH  head instruction word.
- deq_pc  out  ADDR_WIDTH  head PC.
- deq_pred_npc  out  ADDR_WIDTH  head predicted next PC.
- deq_br_taken  out  1  head predicted direction.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers, each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = index bits equal AND wrap bits differ.
  - count = tail − head, modulo 2^($clog2(DEPTH)+1).
- Reset (rst_aL low, asynchronous):
  - head = tail = 0.
  - deq_valid = 0, enq_ready = 1, count = 0.
  - Payload storage is not reset. deq_* payload outputs are don't-care whenever deq_valid = 0.
- Enqueue:
  - Fires when enq_valid & enq_ready & !flush.
  - Writes the entry at tail[idx]; tail increments.
- Dequeue:
  - Fires when deq_valid & deq_ready & !flush.
  - head increments.
- Handshake outputs:
  - enq_ready = !full. It is registered-state only and does not depend on deq_ready; when full, no same-cycle enqueue is allowed even if a dequeue occurs.
  - deq_valid = !empty. Payload outputs are driven combinationally from the storage entry at head[idx].
- Latency:
  - Minimum enqueue-to-dequeue latency is 1 cycle; there is no empty-queue bypass.
  - An entry written at edge N is visible with deq_valid = 1 after edge N.
- Simultaneous enqueue and dequeue when neither full nor empty: both fire, count is unchanged, and head and tail both advance.
- Dequeue from a one-entry queue with a simultaneous enqueue: the new entry becomes head next cycle; deq_valid stays 1.
- Wrap-around:
  - Index bits wrap from DEPTH−1 to 0 and the wrap bit toggles.
  - FIFO order must be preserved across any number of wraps.
- Flush:
  - head = tail = 0 at the next edge; enq/deq in the flush cycle are discarded.
  - flush has priority over enqueue and dequeue.
  - During the flush cycle, enq_ready and deq_valid reflect the pre-flush state. Fetch must treat that cycle's handshake as void.
- Handshake rules:
  - Fetch holds enq_* stable while enq_valid = 1 and enq_ready = 0.
  - The queue holds deq_* stable while deq_valid = 1 and deq_ready = 0.
- No error output. The queue can never overflow or underflow by construction.

Test Plan:
1. Reset then fill: deassert rst_aL; enqueue 8 entries (instr = 0x00000013 + i, pc = 0x1000 + 4i), deq_ready = 0 → count = 8, enq_ready = 0 after the 8th, and a 9th enq_valid is not accepted.
2. Drain order: from the full state, set deq_ready = 1 → deq_pc = 0x1000, 0x1004, … 0x101C on consecutive cycles; deq_valid = 0 and count = 0 afterwards.
3. Simultaneous enqueue and dequeue at count = 3 for 20 cycles → count stays 3, pointers wrap more than twice, and output order matches input order exactly.
4. Empty-to-valid latency: enqueue pc = 0x2000 at edge N with the queue empty → deq_valid = 0 before edge N and 1 with deq_pc = 0x2000 after it.
5. Flush with concurrent enqueue and dequeue at count = 5 → count = 0 and deq_valid = 0 next cycle; the flushed-cycle enqueue (pc = 0x3000) never appears at the dequeue side.
6. Asynchronous reset mid-operation: assert rst_aL low between edges at count = 4 → deq_valid = 0, enq_ready = 1, count = 0 immediately, without waiting for a clock edge.
